// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: access FSM encoding, EX/MEM record layout,
// and the forward-select codes used by execute and the hazard unit.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StDone = 2'd2
  } mem_state_e;

  localparam logic [1:0] FW_REG = 2'b00;
  localparam logic [1:0] FW_MEM = 2'b01;
  localparam logic [1:0] FW_WB  = 2'b10;

  localparam int unsigned CntW = 8;

  typedef struct packed {
    logic        wreg;
    logic        m2reg;
    logic        wmem;
    logic [31:0] alu_r;
    logic [31:0] in_b;
    logic [4:0]  dest_r;
    logic        branch;
    logic        zero;
    logic [31:0] pc;
    logic [3:0]  ins_type;
    logic [3:0]  ins_number;
  } exmem_t;

endpackage

// File: rtl/mem_stage_reg_exe_mem.sv
// EX/MEM pipeline register (Reg_EXE_MEM): synchronous clear, holds while the
// memory stage is stalled.
module mem_stage_reg_exe_mem
  import mem_stage_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   hold_i,
  input  exmem_t d_i,
  output exmem_t q_o
);

  exmem_t q_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q <= '0;
    end else if (!hold_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/mem_stage.sv
// MIPS memory-access stage: req/ack data-memory handshake with timeout, branch
// resolution, forwarding sources and the MEM/WB register.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_wreg,
  input  logic        ex_m2reg,
  input  logic        ex_wmem,
  input  logic [31:0] ex_aluR,
  input  logic [31:0] ex_inB,
  input  logic [4:0]  ex_destR,
  input  logic        ex_branch,
  input  logic        ex_zero,
  input  logic [31:0] ex_pc,
  input  logic [3:0]  EXE_ins_type,
  input  logic [3:0]  EXE_ins_number,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic        mem_stall,
  output logic [31:0] mem_aluR,
  output logic        mem_pcsrc,
  output logic [31:0] mem_branch_pc,
  output logic        mem_err,
  output logic        wb_wreg,
  output logic [4:0]  wb_destR,
  output logic [31:0] wb_dest,
  output logic        wb_m2reg,
  output logic [3:0]  MEM_ins_type,
  output logic [3:0]  MEM_ins_number
);

  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT - 1);

  exmem_t     ex_d, exm_q;
  mem_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mem_op, req;

  logic        wb_wreg_q, wb_wreg_d;
  logic        wb_m2reg_q, wb_m2reg_d;
  logic [4:0]  wb_dest_r_q, wb_dest_r_d;
  logic [31:0] wb_dest_q, wb_dest_d;

  assign ex_d = '{
    wreg:       ex_wreg,
    m2reg:      ex_m2reg,
    wmem:       ex_wmem,
    alu_r:      ex_aluR,
    in_b:       ex_inB,
    dest_r:     ex_destR,
    branch:     ex_branch,
    zero:       ex_zero,
    pc:         ex_pc,
    ins_type:   EXE_ins_type,
    ins_number: EXE_ins_number
  };

  mem_stage_reg_exe_mem u_reg_exe_mem (
    .clk_i  (clk),
    .rst_i  (rst),
    .hold_i (req),
    .d_i    (ex_d),
    .q_o    (exm_q)
  );

  assign mem_op = exm_q.m2reg | exm_q.wmem;
  // cnt_q counts request cycles already spent; it is zero whenever IDLE issues.
  assign req    = ((state_q == StIdle) && mem_op) || (state_q == StWait);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    if (state_q == StDone) begin
      cnt_d   = '0;
      state_d = StIdle;
    end else if (req) begin
      if (dm_ack) begin
        rdata_d = dm_rdata;
        state_d = StDone;
      end else if (cnt_q == TimeoutLast) begin
        err_d   = 1'b1;
        rdata_d = '0;
        state_d = StDone;
      end else begin
        cnt_d   = cnt_q + CntW'(1);
        state_d = StWait;
      end
    end else if (state_q != StIdle) begin
      state_d = StIdle;
    end
  end

  always_comb begin
    wb_wreg_d   = 1'b0;
    wb_m2reg_d  = 1'b0;
    wb_dest_r_d = '0;
    wb_dest_d   = '0;
    if (!req) begin
      wb_wreg_d   = exm_q.wreg;
      wb_m2reg_d  = exm_q.m2reg;
      wb_dest_r_d = exm_q.dest_r;
      wb_dest_d   = exm_q.m2reg ? rdata_q : exm_q.alu_r;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      wb_wreg_q   <= 1'b0;
      wb_m2reg_q  <= 1'b0;
      wb_dest_r_q <= '0;
      wb_dest_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      wb_wreg_q   <= wb_wreg_d;
      wb_m2reg_q  <= wb_m2reg_d;
      wb_dest_r_q <= wb_dest_r_d;
      wb_dest_q   <= wb_dest_d;
    end
  end

  assign dm_req         = req;
  assign mem_stall      = req;
  assign dm_we          = exm_q.wmem;
  assign dm_addr        = exm_q.alu_r;
  assign dm_wdata       = exm_q.in_b;
  assign mem_aluR       = exm_q.alu_r;
  assign mem_pcsrc      = exm_q.branch & exm_q.zero;
  assign mem_branch_pc  = exm_q.pc;
  assign mem_err        = err_q;
  assign wb_wreg        = wb_wreg_q;
  assign wb_m2reg       = wb_m2reg_q;
  assign wb_destR       = wb_dest_r_q;
  assign wb_dest        = wb_dest_q;
  assign MEM_ins_type   = exm_q.ins_type;
  assign MEM_ins_number = exm_q.ins_number;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: table of non-memory instructions, then hand-written
// load/store, timeout and reset-during-wait sequences.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_wreg, ex_m2reg, ex_wmem, ex_branch, ex_zero;
  logic [31:0] ex_aluR, ex_inB, ex_pc;
  logic [4:0]  ex_destR;
  logic [3:0]  EXE_ins_type, EXE_ins_number;
  logic        dm_req, dm_we, dm_ack;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        mem_stall, mem_pcsrc, mem_err, wb_wreg, wb_m2reg;
  logic [31:0] mem_aluR, mem_branch_pc, wb_dest;
  logic [4:0]  wb_destR;
  logic [3:0]  MEM_ins_type, MEM_ins_number;

  int n_vec  = 0;
  int n_fail = 0;

  mem_stage #(.TIMEOUT(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .ex_wreg        (ex_wreg),
    .ex_m2reg       (ex_m2reg),
    .ex_wmem        (ex_wmem),
    .ex_aluR        (ex_aluR),
    .ex_inB         (ex_inB),
    .ex_destR       (ex_destR),
    .ex_branch      (ex_branch),
    .ex_zero        (ex_zero),
    .ex_pc          (ex_pc),
    .EXE_ins_type   (EXE_ins_type),
    .EXE_ins_number (EXE_ins_number),
    .dm_req         (dm_req),
    .dm_we          (dm_we),
    .dm_addr        (dm_addr),
    .dm_wdata       (dm_wdata),
    .dm_rdata       (dm_rdata),
    .dm_ack         (dm_ack),
    .mem_stall      (mem_stall),
    .mem_aluR       (mem_aluR),
    .mem_pcsrc      (mem_pcsrc),
    .mem_branch_pc  (mem_branch_pc),
    .mem_err        (mem_err),
    .wb_wreg        (wb_wreg),
    .wb_destR       (wb_destR),
    .wb_dest        (wb_dest),
    .wb_m2reg       (wb_m2reg),
    .MEM_ins_type   (MEM_ins_type),
    .MEM_ins_number (MEM_ins_number)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wreg;
    logic        branch;
    logic        zero;
    logic [31:0] alu;
    logic [4:0]  dest;
    logic [31:0] pc;
    logic [3:0]  typ;
    logic [3:0]  num;
    logic        e_pcsrc;
    logic        e_wb_wreg;
    logic [4:0]  e_wb_dest_r;
    logic [31:0] e_wb_dest;
  } vec_t;

  vec_t vecs [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_ex(input logic wreg, input logic m2reg, input logic wmem,
                        input logic [31:0] alu, input logic [31:0] inb, input logic [4:0] dest,
                        input logic branch, input logic zero, input logic [31:0] pc,
                        input logic [3:0] typ, input logic [3:0] num);
    ex_wreg = wreg; ex_m2reg = m2reg; ex_wmem = wmem; ex_aluR = alu; ex_inB = inb;
    ex_destR = dest; ex_branch = branch; ex_zero = zero; ex_pc = pc;
    EXE_ins_type = typ; EXE_ins_number = num;
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {dm_req, dm_we, dm_addr, dm_wdata, mem_stall, mem_aluR, mem_pcsrc,
               mem_branch_pc, mem_err, wb_wreg, wb_destR, wb_dest, wb_m2reg,
               MEM_ins_type, MEM_ins_number}, '0);
  endtask

  // Walk one access from its first request cycle; ack_at < 0 means never acknowledge.
  task automatic run_mem(input int ack_at, input logic [31:0] rdata, output int cycles);
    cycles = 0;
    for (int c = 0; c < 40; c++) begin
      if (!dm_req) break;
      cycles++;
      chk("stall_during_req", mem_stall, 1'b1);
      chk("err_clear_during_req", mem_err, 1'b0);
      if (c > 0) chk("wb_bubble", wb_wreg, 1'b0);
      dm_rdata = rdata;
      dm_ack   = (c == ack_at);
      tick();
    end
    dm_ack = 1'b0;
    chk("done_no_stall", {dm_req, mem_stall}, 2'b00);
  endtask

  initial begin
    int cyc;
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h1234,     5'd5,  32'h0,   4'h1, 4'h1, 1'b0, 1'b0, 5'd0,  32'h0};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 32'h0,        5'd0,  32'h100, 4'h2, 4'h2, 1'b1, 1'b1, 5'd5,  32'h1234};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h55,       5'd0,  32'h200, 4'h3, 4'h3, 1'b0, 1'b0, 5'd0,  32'h0};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 5'd31, 32'h0,   4'hF, 4'h4, 1'b0, 1'b0, 5'd0,  32'h55};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 32'h0,        5'd0,  32'h0,   4'h0, 4'h5, 1'b0, 1'b1, 5'd31, 32'hFFFFFFFF};

    rst = 1'b1; dm_ack = 1'b0; dm_rdata = 32'h0;
    set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    chk_all_zero("reset_state");
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      set_ex(vecs[i].wreg, 0, 0, vecs[i].alu, 0, vecs[i].dest, vecs[i].branch, vecs[i].zero,
             vecs[i].pc, vecs[i].typ, vecs[i].num);
      tick();
      chk($sformatf("v%0d_stall", i), {dm_req, mem_stall}, 2'b00);
      chk($sformatf("v%0d_aluR", i), mem_aluR, vecs[i].alu);
      chk($sformatf("v%0d_pcsrc", i), mem_pcsrc, vecs[i].e_pcsrc);
      chk($sformatf("v%0d_bpc", i), mem_branch_pc, vecs[i].pc);
      chk($sformatf("v%0d_tags", i), {MEM_ins_type, MEM_ins_number}, {vecs[i].typ, vecs[i].num});
      chk($sformatf("v%0d_wb", i), {wb_wreg, wb_m2reg, wb_destR, wb_dest},
          {vecs[i].e_wb_wreg, 1'b0, vecs[i].e_wb_dest_r, vecs[i].e_wb_dest});
    end

    // Load A with ack on the 4th request cycle, load B queued behind it.
    set_ex(1, 1, 0, 32'h40, 32'h0, 5'd7, 0, 0, 0, 4'h6, 4'h6);
    tick();
    set_ex(1, 1, 0, 32'h44, 32'h0, 5'd8, 0, 0, 0, 4'h7, 4'h7);
    chk("ldA_port", {dm_req, dm_we, dm_addr}, {1'b1, 1'b0, 32'h40});
    run_mem(3, 32'hDEADBEEF, cyc);
    chk("ldA_req_cycles", cyc, 4);
    tick();
    chk("ldA_wb", {wb_wreg, wb_m2reg, wb_destR, wb_dest}, {1'b1, 1'b1, 5'd7, 32'hDEADBEEF});
    chk("ldB_back_to_back", {dm_req, dm_addr}, {1'b1, 32'h44});

    // Load B acked at once; store follows.
    set_ex(0, 0, 1, 32'h80, 32'hCAFEF00D, 5'd0, 0, 0, 0, 4'h8, 4'h8);
    run_mem(0, 32'h12345678, cyc);
    chk("ldB_req_cycles", cyc, 1);
    tick();
    chk("ldB_wb", {wb_wreg, wb_m2reg, wb_destR, wb_dest}, {1'b1, 1'b1, 5'd8, 32'h12345678});
    chk("st_port", {dm_req, dm_we, dm_addr, dm_wdata}, {1'b1, 1'b1, 32'h80, 32'hCAFEF00D});
    set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_mem(0, 32'h11111111, cyc);
    chk("st_stall_cycles", cyc, 1);
    tick();
    chk("st_wb", {wb_wreg, wb_m2reg, wb_dest}, {1'b0, 1'b0, 32'h80});

    // Unacknowledged load runs into the timeout.
    set_ex(1, 1, 0, 32'h200, 32'h0, 5'd9, 0, 0, 0, 4'h9, 4'h9);
    tick();
    set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_mem(-1, 32'hA5A5A5A5, cyc);
    chk("to_req_cycles", cyc, 16);
    chk("to_err_set", mem_err, 1'b1);
    tick();
    chk("to_wb", {wb_wreg, wb_m2reg, wb_destR, wb_dest}, {1'b1, 1'b1, 5'd9, 32'h0});
    tick(); tick();
    chk("to_err_sticky", {mem_err, dm_req}, 2'b10);

    // Reset while waiting, followed by a late ack.
    set_ex(1, 1, 0, 32'h300, 32'h0, 5'd3, 0, 0, 0, 4'hA, 4'hA);
    tick();
    set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("wait_before_rst", {dm_req, mem_stall}, 2'b11);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all_zero("rst_in_wait");
    dm_ack = 1'b1; dm_rdata = 32'hBAD0BAD0;
    tick();
    dm_ack = 1'b0;
    chk_all_zero("late_ack_ignored");
    tick();
    chk_all_zero("idle_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
